// File: rtl/hazard_stall_unit_if.sv
// Hazard/stall interface: decode-stage hazard inputs from the pipeline, and the
// interlock controls plus performance counters that go back to it.
interface hazard_stall_unit_if #(
  parameter int CNT_W = 16
);
  // Operand fields and usage of the instruction sitting in ID
  logic [4:0]       IF_ID_RegRs;
  logic [4:0]       IF_ID_RegRt;
  logic             ID_UseRs;
  logic             ID_UseRt;
  logic             IDControl_Branch;
  // Producer in EX
  logic             ID_EX_MemRead;
  logic             ID_EX_RegWrite;
  logic [4:0]       ID_EX_RegRd;
  // Producer in MEM
  logic             EX_MEM_MemRead;
  logic [4:0]       EX_MEM_RegRd;
  // Redirect and counter control
  logic [2:0]       PCSrc;
  logic             Cnt_Clear;
  // Interlock controls
  logic             PC_Write;
  logic             IF_ID_Write;
  logic             ID_EX_Flush;
  logic             IF_ID_Flush;
  // Performance counters
  logic [CNT_W-1:0] Stall_Count;
  logic [CNT_W-1:0] Flush_Count;

  // Pipeline side: supplies hazard inputs, consumes interlock controls
  modport master (
    output IF_ID_RegRs, IF_ID_RegRt, ID_UseRs, ID_UseRt, IDControl_Branch,
           ID_EX_MemRead, ID_EX_RegWrite, ID_EX_RegRd,
           EX_MEM_MemRead, EX_MEM_RegRd, PCSrc, Cnt_Clear,
    input  PC_Write, IF_ID_Write, ID_EX_Flush, IF_ID_Flush,
           Stall_Count, Flush_Count
  );

  // Interlock side
  modport slave (
    input  IF_ID_RegRs, IF_ID_RegRt, ID_UseRs, ID_UseRt, IDControl_Branch,
           ID_EX_MemRead, ID_EX_RegWrite, ID_EX_RegRd,
           EX_MEM_MemRead, EX_MEM_RegRd, PCSrc, Cnt_Clear,
    output PC_Write, IF_ID_Write, ID_EX_Flush, IF_ID_Flush,
           Stall_Count, Flush_Count
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Pipeline interlock beside ID. Catches the hazards forwarding cannot cover:
// load-use, ALU result needed by a branch in ID, and load results needed by a
// branch in ID (two cycles when the load is still in EX). Freezes PC and IF/ID,
// bubbles ID/EX, squashes IF/ID on a taken redirect, and counts stall/flush
// cycles with saturating counters.
module hazard_stall_unit #(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,   // asynchronous, active low
  hazard_stall_unit_if.slave   hz
);

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic m_ex, m_mem;
  logic h_lu, h_ba, h_ble, h_blm;
  logic stall_raw, stall, flush;

  // Does register r feed an operand the ID instruction actually reads? $0 never does.
  function automatic logic reg_match(input logic [4:0] r,
                                     input logic [4:0] rs, input logic [4:0] rt,
                                     input logic use_rs, input logic use_rt);
    return (r != 5'd0) && ((use_rs && (r == rs)) || (use_rt && (r == rt)));
  endfunction

  // Hazard classification against the EX and MEM producers
  always_comb begin
    m_ex  = reg_match(hz.ID_EX_RegRd, hz.IF_ID_RegRs, hz.IF_ID_RegRt,
                      hz.ID_UseRs, hz.ID_UseRt);
    m_mem = reg_match(hz.EX_MEM_RegRd, hz.IF_ID_RegRs, hz.IF_ID_RegRt,
                      hz.ID_UseRs, hz.ID_UseRt);
    h_lu  = hz.ID_EX_MemRead && m_ex;
    h_ba  = hz.IDControl_Branch && hz.ID_EX_RegWrite && !hz.ID_EX_MemRead && m_ex;
    h_ble = hz.IDControl_Branch && h_lu;
    h_blm = hz.IDControl_Branch && hz.EX_MEM_MemRead && m_mem;
  end

  // Next state and raw stall request; HOLD adds the second cycle a branch
  // needs when its operand is a load still in EX
  always_comb begin
    state_d   = state_q;
    stall_raw = 1'b0;
    unique case (state_q)
      RUN: begin
        stall_raw = h_lu | h_ba | h_blm;
        if (h_ble) state_d = HOLD;
      end
      HOLD: begin
        stall_raw = 1'b1;
        state_d   = RUN;
      end
      default: begin
        stall_raw = 1'b0;
        state_d   = RUN;
      end
    endcase
  end

  // Output gating: reset low forces idle controls even though they are
  // combinational. Stall beats the redirect squash since branch operands are stale.
  always_comb begin
    stall = stall_raw && reset;
    flush = (hz.PCSrc != 3'd0) && !stall && reset;
  end

  assign hz.PC_Write    = ~stall;
  assign hz.IF_ID_Write = ~stall;
  assign hz.ID_EX_Flush = stall;
  assign hz.IF_ID_Flush = flush;
  assign hz.Stall_Count = stall_cnt_q;
  assign hz.Flush_Count = flush_cnt_q;

  // Saturating counter next values; clear wins over increment
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (hz.Cnt_Clear) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
      if (flush && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  // State and counter registers; reset abandons any pending HOLD cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: a table of single-cycle vectors for the
// combinational hazard classes, plus sequences for the two-cycle branch-after-load
// stall, reset during HOLD, and counter saturation/clear (4-bit copy).
module tb_hazard_stall_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [4:0] rs, rt, ex_rd, mem_rd;
  logic       use_rs, use_rt, br, ex_mr, ex_rw, mem_mr, clr;
  logic [2:0] pcsrc;

  hazard_stall_unit_if #(.CNT_W(16)) hif  ();
  hazard_stall_unit_if #(.CNT_W(4))  hif4 ();

  assign hif.IF_ID_RegRs = rs;       assign hif4.IF_ID_RegRs = rs;
  assign hif.IF_ID_RegRt = rt;       assign hif4.IF_ID_RegRt = rt;
  assign hif.ID_UseRs = use_rs;      assign hif4.ID_UseRs = use_rs;
  assign hif.ID_UseRt = use_rt;      assign hif4.ID_UseRt = use_rt;
  assign hif.IDControl_Branch = br;  assign hif4.IDControl_Branch = br;
  assign hif.ID_EX_MemRead = ex_mr;  assign hif4.ID_EX_MemRead = ex_mr;
  assign hif.ID_EX_RegWrite = ex_rw; assign hif4.ID_EX_RegWrite = ex_rw;
  assign hif.ID_EX_RegRd = ex_rd;    assign hif4.ID_EX_RegRd = ex_rd;
  assign hif.EX_MEM_MemRead = mem_mr; assign hif4.EX_MEM_MemRead = mem_mr;
  assign hif.EX_MEM_RegRd = mem_rd;  assign hif4.EX_MEM_RegRd = mem_rd;
  assign hif.PCSrc = pcsrc;          assign hif4.PCSrc = pcsrc;
  assign hif.Cnt_Clear = clr;        assign hif4.Cnt_Clear = clr;

  hazard_stall_unit #(.CNT_W(16)) u_dut  (.clk(clk), .reset(reset), .hz(hif.slave));
  hazard_stall_unit #(.CNT_W(4))  u_dut4 (.clk(clk), .reset(reset), .hz(hif4.slave));

  int errors = 0;
  int checks = 0;
  int exp_sc = 0;
  int exp_fc = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Checks all four interlock outputs against an expected stall/flush pair
  task automatic chk_ctl(input string name, input logic s, input logic f);
    chk({name, ".PC_Write"},    int'(hif.PC_Write),    int'(!s));
    chk({name, ".IF_ID_Write"}, int'(hif.IF_ID_Write), int'(!s));
    chk({name, ".ID_EX_Flush"}, int'(hif.ID_EX_Flush), int'(s));
    chk({name, ".IF_ID_Flush"}, int'(hif.IF_ID_Flush), int'(f));
  endtask

  task automatic chk_cnt(input string name);
    chk({name, ".Stall_Count"},  int'(hif.Stall_Count),  exp_sc);
    chk({name, ".Flush_Count"},  int'(hif.Flush_Count),  exp_fc);
    chk({name, ".Stall_Count4"}, int'(hif4.Stall_Count), (exp_sc > 15) ? 15 : exp_sc);
    chk({name, ".Flush_Count4"}, int'(hif4.Flush_Count), (exp_fc > 15) ? 15 : exp_fc);
  endtask

  task automatic idle_in();
    rs = 0; rt = 0; use_rs = 0; use_rt = 0; br = 0;
    ex_mr = 0; ex_rw = 0; ex_rd = 0; mem_mr = 0; mem_rd = 0;
    pcsrc = 0; clr = 0;
  endtask

  // lw $8 in EX, beq $8,$9 in ID: branch waits on a load still in EX
  task automatic set_ble();
    idle_in();
    rs = 8; rt = 9; use_rs = 1; use_rt = 1; br = 1;
    ex_mr = 1; ex_rw = 1; ex_rd = 8;
  endtask

  typedef struct {
    string      name;
    logic [4:0] rs, rt;
    logic       use_rs, use_rt, br, ex_mr, ex_rw;
    logic [4:0] ex_rd;
    logic       mem_mr;
    logic [4:0] mem_rd;
    logic [2:0] pcsrc;
    logic       e_stall, e_flush;
  } vec_t;

  vec_t vt[15];

  initial begin
    //         name           rs rt urs urt br emr erw erd mmr mrd pc  stl fl
    vt[0]  = '{"idle",         0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[1]  = '{"lu_rs",        8, 4, 1, 1, 0, 1, 1, 8, 0, 0, 0, 1, 0};
    vt[2]  = '{"lu_miss",      8, 4, 1, 1, 0, 1, 1, 5, 0, 0, 0, 0, 0};
    vt[3]  = '{"lu_rt",        1, 8, 1, 1, 0, 1, 1, 8, 0, 0, 0, 1, 0};
    vt[4]  = '{"lu_rt_unused", 1, 8, 1, 0, 0, 1, 1, 8, 0, 0, 0, 0, 0};
    vt[5]  = '{"lu_r0",        0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0};
    vt[6]  = '{"ba_hit",       9, 0, 1, 1, 1, 0, 1, 9, 0, 0, 0, 1, 0};
    vt[7]  = '{"ba_rd0",       9, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0};
    vt[8]  = '{"alu_nobr",     9, 0, 1, 1, 0, 0, 1, 9, 0, 0, 0, 0, 0};
    vt[9]  = '{"blm_hit",      7, 2, 1, 1, 1, 0, 0, 0, 1, 7, 0, 1, 0};
    vt[10] = '{"mem_nobr",     7, 2, 1, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0};
    vt[11] = '{"redirect",     3, 4, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 1};
    vt[12] = '{"redir_lu",     8, 4, 1, 1, 0, 1, 1, 8, 0, 0, 1, 1, 0};
    vt[13] = '{"redir_blm",    7, 2, 1, 1, 1, 0, 0, 0, 1, 7, 4, 1, 0};
    vt[14] = '{"redir_br_ok",  9, 0, 1, 1, 1, 0, 0, 9, 0, 0, 2, 0, 1};

    idle_in();
    reset = 1'b0;
    #2;
    chk_ctl("reset", 1'b0, 1'b0);
    chk_cnt("reset");
    @(negedge clk); reset = 1'b1;

    // Table: single-cycle hazards in RUN (no branch-after-load here)
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      rs = vt[i].rs; rt = vt[i].rt; use_rs = vt[i].use_rs; use_rt = vt[i].use_rt;
      br = vt[i].br; ex_mr = vt[i].ex_mr; ex_rw = vt[i].ex_rw; ex_rd = vt[i].ex_rd;
      mem_mr = vt[i].mem_mr; mem_rd = vt[i].mem_rd; pcsrc = vt[i].pcsrc;
      #1;
      chk_ctl(vt[i].name, vt[i].e_stall, vt[i].e_flush);
      exp_sc += int'(vt[i].e_stall);
      exp_fc += int'(vt[i].e_flush);
    end
    @(negedge clk); idle_in();
    #1 chk_cnt("table");

    // Branch on a load in EX: two stall cycles even once EX holds the bubble
    @(negedge clk); set_ble();
    #1 chk_ctl("ble_c1", 1'b1, 1'b0);
    @(negedge clk);
    ex_mr = 0; ex_rw = 0; ex_rd = 0;     // bubble now in EX, MEM load hidden
    #1 chk_ctl("ble_c2_hold", 1'b1, 1'b0);
    @(negedge clk); idle_in();
    #1 chk_ctl("ble_c3_run", 1'b0, 1'b0);
    exp_sc += 2;
    @(negedge clk);
    #1 chk_cnt("ble");

    // Reset asserted in HOLD: idle at once, counters zero, no resumed stall
    @(negedge clk); set_ble();
    @(negedge clk);
    pcsrc = 3'd1;
    #1 chk_ctl("pre_rst_hold", 1'b1, 1'b0);
    #1 reset = 1'b0;
    #1;
    exp_sc = 0; exp_fc = 0;
    chk_ctl("rst_in_hold", 1'b0, 1'b0);
    chk_cnt("rst_in_hold");
    @(negedge clk); idle_in();
    @(negedge clk); reset = 1'b1;
    #1 chk_ctl("rst_release", 1'b0, 1'b0);
    @(negedge clk);
    #1 chk_ctl("rst_run", 1'b0, 1'b0);
    chk_cnt("rst_run");

    // 20 back-to-back load-use stalls: 4-bit copy saturates at 15
    @(negedge clk);
    rs = 8; use_rs = 1; ex_mr = 1; ex_rw = 1; ex_rd = 8;
    repeat (20) @(negedge clk);
    exp_sc += 20;
    idle_in();
    #1 chk_cnt("sat");
    chk("sat4_exact", int'(hif4.Stall_Count), 15);

    // Clear wins over a concurrent stall increment
    @(negedge clk);
    rs = 8; use_rs = 1; ex_mr = 1; ex_rw = 1; ex_rd = 8; clr = 1;
    @(negedge clk); idle_in();
    exp_sc = 0; exp_fc = 0;
    #1 chk_cnt("clear");

    // Flush counter after clear
    @(negedge clk); pcsrc = 3'd7;
    @(negedge clk); idle_in();
    exp_fc = 1;
    #1 chk_cnt("flush_after_clear");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
